// File: rtl/hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard sequencer and the pipeline buffers.
// Also provides the FSM state type and a counter-sizing helper.
package hazard_controller_pkg;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_POP = 2'b10;
  localparam logic [1:0] PC_SRC_RST = 2'b11;

  typedef enum logic [1:0] {
    StRstHold,
    StRun,
    StLdStall,
    StRetWait
  } state_e;

  // Bit positions inside the control word carried by the FD/DE/EM/MW buffers.
  localparam int unsigned CTRL_MEM_R     = 0;
  localparam int unsigned CTRL_REG_WRITE = 1;
  localparam int unsigned CTRL_POP_PC    = 2;
  localparam int unsigned CTRL_W         = 3;

  // Width of a counter that must reach max(a, b) - 1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hazard_compare.sv
// Combinational load-use match between the decode sources and the load in execute.
// Kept standalone so a forwarding unit can reuse the same comparison.
module hazard_compare (
  input  logic       mem_read,
  input  logic       valid,
  input  logic [2:0] src1,
  input  logic [2:0] src2,
  input  logic       use1,
  input  logic       use2,
  input  logic [2:0] write_add,
  output logic       hazard
);

  // Register 0 is an ordinary register, so an address-0 match still counts.
  assign hazard = mem_read & valid &
                  ((use1 & (src1 == write_add)) | (use2 & (src2 == write_add)));

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: PC source select, PC/FD enables, FD/DE bubbles and a
// saturating stall-cycle counter for load-use, taken-branch, RET and boot handling.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned RESET_CYCLES      = 2,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [2:0]       dec_src1,
  input  logic [2:0]       dec_src2,
  input  logic             dec_use1,
  input  logic             dec_use2,
  input  logic             dec_ret,
  input  logic             ex_mem_read,
  input  logic [2:0]       ex_write_add,
  input  logic             ex_branch_taken,
  input  logic             mem_pc_valid,
  output logic [1:0]       pc_src,
  output logic             pc_write,
  output logic             fd_write,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned CW = cnt_width(RESET_CYCLES, LOAD_STALL_CYCLES);
  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] LD_LAST  = CW'(LOAD_STALL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             hazard;

  hazard_compare u_hazard_compare (
    .mem_read  (ex_mem_read),
    .valid     (dec_valid),
    .src1      (dec_src1),
    .src2      (dec_src2),
    .use1      (dec_use1),
    .use2      (dec_use2),
    .write_add (ex_write_add),
    .hazard    (hazard)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRstHold;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRstHold: begin
        if (cnt_q == RST_LAST) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        // A taken branch squashes decode, so it masks RET and load-use.
        if (!ex_branch_taken) begin
          if (dec_ret && dec_valid) begin
            state_d = StRetWait;
          end else if (hazard && (LOAD_STALL_CYCLES > 1)) begin
            state_d = StLdStall;
            cnt_d   = CW'(1);
          end
        end
      end
      StLdStall: begin
        if (cnt_q == LD_LAST) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRetWait: begin
        if (mem_pc_valid) state_d = StRun;
      end
      default: state_d = StRstHold;
    endcase
  end

  always_comb begin
    pc_src   = PC_SRC_SEQ;
    pc_write = 1'b1;
    fd_write = 1'b1;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    unique case (state_q)
      StRstHold: begin
        pc_src   = PC_SRC_RST;
        fd_write = 1'b0;
        fd_flush = 1'b1;
        de_flush = 1'b1;
        // Gate with reset so the vector is never loaded while reset is still held.
        pc_write = (cnt_q == RST_LAST) && reset;
      end
      StRun: begin
        if (ex_branch_taken) begin
          pc_src   = PC_SRC_BR;
          fd_flush = 1'b1;
          de_flush = 1'b1;
        end else if (dec_ret && dec_valid) begin
          pc_write = 1'b0;
          fd_flush = 1'b1;
        end else if (hazard) begin
          pc_write = 1'b0;
          fd_write = 1'b0;
          de_flush = 1'b1;
        end
      end
      StLdStall: begin
        pc_write = 1'b0;
        fd_write = 1'b0;
        de_flush = 1'b1;
      end
      StRetWait: begin
        fd_flush = 1'b1;
        if (mem_pc_valid) begin
          pc_src = PC_SRC_POP;
        end else begin
          pc_write = 1'b0;
        end
      end
      default: begin
        pc_write = 1'b0;
        fd_write = 1'b0;
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_write && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
  end

  assign busy        = (state_q != StRun);
  assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench: two controller configurations share randomized stimulus and are
// checked every cycle against a phase-based reference model.
module tb_hazard_controller;

  localparam int RC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid, dec_use1, dec_use2, dec_ret;
  logic [2:0] dec_src1, dec_src2, ex_write_add;
  logic       ex_mem_read, ex_branch_taken, mem_pc_valid;

  logic [1:0]  pc_src_a, pc_src_b;
  logic        pc_write_a, fd_write_a, fd_flush_a, de_flush_a, busy_a;
  logic        pc_write_b, fd_write_b, fd_flush_b, de_flush_b, busy_b;
  logic [15:0] stall_count_a;
  logic [3:0]  stall_count_b;

  always #5 clk = ~clk;

  hazard_controller #(.RESET_CYCLES(RC), .LOAD_STALL_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_src1(dec_src1),
    .dec_src2(dec_src2), .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_ret(dec_ret),
    .ex_mem_read(ex_mem_read), .ex_write_add(ex_write_add),
    .ex_branch_taken(ex_branch_taken), .mem_pc_valid(mem_pc_valid),
    .pc_src(pc_src_a), .pc_write(pc_write_a), .fd_write(fd_write_a),
    .fd_flush(fd_flush_a), .de_flush(de_flush_a), .busy(busy_a),
    .stall_count(stall_count_a)
  );

  hazard_controller #(.RESET_CYCLES(RC), .LOAD_STALL_CYCLES(2), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_src1(dec_src1),
    .dec_src2(dec_src2), .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_ret(dec_ret),
    .ex_mem_read(ex_mem_read), .ex_write_add(ex_write_add),
    .ex_branch_taken(ex_branch_taken), .mem_pc_valid(mem_pc_valid),
    .pc_src(pc_src_b), .pc_write(pc_write_b), .fd_write(fd_write_b),
    .fd_flush(fd_flush_b), .de_flush(de_flush_b), .busy(busy_b),
    .stall_count(stall_count_b)
  );

  typedef struct packed {
    logic [1:0]  pc_src;
    logic        pc_write;
    logic        fd_write;
    logic        fd_flush;
    logic        de_flush;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   checks = 0;
  int   errors = 0;

  // Reference model, per configuration k: boot countdown, remaining extra bubbles,
  // outstanding RET, and stall cycles seen so far.
  bit booting[2];
  int boot_left[2];
  int ld_left[2];
  bit ret_wait[2];
  int stalls[2];

  function automatic int ld_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int cmax_of(input int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  function automatic exp_t model_step(input int k);
    exp_t e;
    bit   hz;
    e = '{pc_src: 2'd0, pc_write: 1'b1, fd_write: 1'b1, fd_flush: 1'b0, de_flush: 1'b0,
          busy: 1'b0, cnt: 16'(stalls[k])};
    if (!reset) begin
      e = '{pc_src: 2'd3, pc_write: 1'b0, fd_write: 1'b0, fd_flush: 1'b1, de_flush: 1'b1,
            busy: 1'b1, cnt: 16'd0};
      booting[k] = 1; boot_left[k] = RC - 1; ld_left[k] = 0; ret_wait[k] = 0; stalls[k] = 0;
      return e;
    end
    hz = ex_mem_read && dec_valid &&
         ((dec_use1 && dec_src1 == ex_write_add) || (dec_use2 && dec_src2 == ex_write_add));
    if (booting[k]) begin
      e.pc_src = 2'd3; e.fd_write = 0; e.fd_flush = 1; e.de_flush = 1; e.busy = 1;
      if (boot_left[k] > 0) begin
        e.pc_write = 0;
        boot_left[k]--;
      end else begin
        booting[k] = 0;
      end
    end else if (ld_left[k] > 0) begin
      e.pc_write = 0; e.fd_write = 0; e.de_flush = 1; e.busy = 1;
      ld_left[k]--;
    end else if (ret_wait[k]) begin
      e.busy = 1; e.fd_flush = 1;
      if (mem_pc_valid) begin
        e.pc_src = 2'd2;
        ret_wait[k] = 0;
      end else begin
        e.pc_write = 0;
      end
    end else if (ex_branch_taken) begin
      e.pc_src = 2'd1; e.fd_flush = 1; e.de_flush = 1;
    end else if (dec_ret && dec_valid) begin
      e.pc_write = 0; e.fd_flush = 1;
      ret_wait[k] = 1;
    end else if (hz) begin
      e.pc_write = 0; e.fd_write = 0; e.de_flush = 1;
      ld_left[k] = ld_of(k) - 1;
    end
    if (!e.pc_write && stalls[k] < cmax_of(k)) stalls[k]++;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [2:0] s1, input logic [2:0] s2,
                      input logic u1, input logic u2, input logic rt, input logic mr,
                      input logic [2:0] wa, input logic bt, input logic mpv);
    @(posedge clk);
    #1;
    reset = r; dec_valid = v; dec_src1 = s1; dec_src2 = s2; dec_use1 = u1; dec_use2 = u2;
    dec_ret = rt; ex_mem_read = mr; ex_write_add = wa; ex_branch_taken = bt;
    mem_pc_valid = mpv;
    q_a.push_back(model_step(0));
    q_b.push_back(model_step(1));
  endtask

  task automatic idle(input int n, input logic mpv);
    repeat (n) step(1, 1, 3'd1, 3'd2, 1, 1, 0, 0, 3'd5, 0, mpv);
  endtask

  // Monitor: every cycle the DUT presents a full output vector.
  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      ea = q_a.pop_front();
      chk("a.pc_src", int'(pc_src_a), int'(ea.pc_src));
      chk("a.pc_write", int'(pc_write_a), int'(ea.pc_write));
      chk("a.fd_write", int'(fd_write_a), int'(ea.fd_write));
      chk("a.fd_flush", int'(fd_flush_a), int'(ea.fd_flush));
      chk("a.de_flush", int'(de_flush_a), int'(ea.de_flush));
      chk("a.busy", int'(busy_a), int'(ea.busy));
      chk("a.stall_count", int'(stall_count_a), int'(ea.cnt));
    end
    if (q_b.size() > 0) begin
      eb = q_b.pop_front();
      chk("b.pc_src", int'(pc_src_b), int'(eb.pc_src));
      chk("b.pc_write", int'(pc_write_b), int'(eb.pc_write));
      chk("b.fd_write", int'(fd_write_b), int'(eb.fd_write));
      chk("b.fd_flush", int'(fd_flush_b), int'(eb.fd_flush));
      chk("b.de_flush", int'(de_flush_b), int'(eb.de_flush));
      chk("b.busy", int'(busy_b), int'(eb.busy));
      chk("b.stall_count", int'(stall_count_b), int'(eb.cnt));
    end
  end

  initial begin
    reset = 0; dec_valid = 0; dec_src1 = 0; dec_src2 = 0; dec_use1 = 0; dec_use2 = 0;
    dec_ret = 0; ex_mem_read = 0; ex_write_add = 0; ex_branch_taken = 0; mem_pc_valid = 0;
    for (int k = 0; k < 2; k++) begin
      booting[k] = 1; boot_left[k] = RC - 1; ld_left[k] = 0; ret_wait[k] = 0; stalls[k] = 0;
    end

    // Reset held three cycles, then boot sequence.
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4, 0);
    // Load-use on src2 == 3.
    step(1, 1, 3'd0, 3'd3, 0, 1, 0, 1, 3'd3, 0, 0);
    idle(3, 0);
    // Load-use on register 0 via src1.
    step(1, 1, 3'd0, 3'd6, 1, 0, 0, 1, 3'd0, 0, 0);
    idle(3, 0);
    // Load-use masked by a simultaneous taken branch.
    step(1, 1, 3'd0, 3'd3, 0, 1, 1, 1, 3'd3, 1, 0);
    idle(2, 0);
    // RET, popped PC returns three cycles after the RET was in decode.
    step(1, 1, 3'd0, 3'd0, 0, 0, 1, 0, 3'd0, 0, 0);
    idle(2, 0);
    idle(1, 1);
    idle(2, 0);
    // Reset asserted mid RET wait; later pops during boot are ignored.
    step(1, 1, 3'd0, 3'd0, 0, 0, 1, 0, 3'd0, 0, 0);
    idle(1, 0);
    step(0, 1, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1);
    idle(3, 1);
    // Long RET wait pushes the narrow counter into saturation.
    step(1, 1, 3'd0, 3'd0, 0, 0, 1, 0, 3'd0, 0, 0);
    idle(20, 0);
    idle(1, 1);
    idle(2, 0);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) != 0), 1'($urandom), 3'($urandom_range(0, 3)),
           3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 9) == 0), 1'($urandom), 3'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    #1;
    chk("queue_drain", q_a.size() + q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central sequencer for the 5-stage pipeline (Fetch, FD, Decode, DE, Execute, EM, Memory, MW, WriteBack).
- Generates the PC-source select, PC/FD write enables and FD/DE flush (bubble) controls.
- Resolves load-use hazards, taken branches, RET (pop-PC) waits and the post-reset PC load.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- RESET_CYCLES, 2, cycles the pipeline is held after reset release before the reset-vector PC is loaded (≥1).
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (≥1).
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-low reset.
- dec_valid  input  1  FD buffer holds a real instruction.
- dec_src1, dec_src2  input  3 each  Rsrc addresses of the instruction in decode.
- dec_use1, dec_use2  input  1 each  decode instruction actually reads src1/src2.
- dec_ret  input  1  decode instruction is RET/RTI (PopPc).
- ex_mem_read  input  1  instruction in execute has MemR set.
- ex_write_add  input  3  destination register of the instruction in execute.
- ex_branch_taken  input  1  execute resolved a taken branch/jump.
- mem_pc_valid  input  1  memory stage returns the popped PC this cycle.
- pc_src  output  2  00 sequential, 01 branch target, 10 popped PC, 11 reset vector.
- pc_write  output  1  fetch PC register enable.
- fd_write  output  1  FD buffer enable (0 = hold).
- fd_flush  output  1  FD buffer loads NOP.
- de_flush  output  1  DE buffer loads all-zero control signals.
- busy  output  1  FSM not in RUN.
- stall_count  output  CNT_W  saturating count of cycles with pc_write=0.

Behaviour:
- Reset (async, reset=0):
  - FSM=RST_HOLD, counter=0, stall_count=0.
  - Outputs: pc_write=0, fd_write=0, fd_flush=1, de_flush=1, pc_src=11, busy=1.
  - Reset asserted in any state aborts that state immediately.
- Outputs are combinational from state plus inputs; state, counters and stall_count are registered on the rising edge of clk.
- RST_HOLD:
  - Counts to RESET_CYCLES-1 with pc_write=0, fd_flush=1, de_flush=1.
  - On the final count: pc_src=11, pc_write=1. Next state RUN.
- RUN defaults: pc_src=00, pc_write=1, fd_write=1, flushes 0, busy=0.
- RUN events, in priority order (highest first):
  1. ex_branch_taken:
     - pc_src=01, pc_write=1, fd_flush=1, de_flush=1.
     - Stays in RUN; overrides any simultaneous hazard or dec_ret, since the decode instruction is squashed.
  2. dec_ret & dec_valid:
     - pc_write=0, fd_flush=1. Next state RET_WAIT.
  3. Load-use: hazard = ex_mem_read & dec_valid & ((dec_use1 & dec_src1==ex_write_add) | (dec_use2 & dec_src2==ex_write_add)).
     - pc_write=0, fd_write=0, de_flush=1.
     - If LOAD_STALL_CYCLES>1, next state LD_STALL with counter=1; otherwise stay in RUN. The next cycle's execute instruction is the bubble, so the hazard clears.
- LD_STALL:
  - Holds pc_write=0, fd_write=0, de_flush=1.
  - Counter increments; when it reaches LOAD_STALL_CYCLES-1, next state RUN.
  - ex_branch_taken here is ignored; execute holds a bubble, so it must be 0.
- RET_WAIT:
  - pc_write=0, fd_flush=1, de_flush=0; older instructions drain.
  - When mem_pc_valid=1: pc_src=10, pc_write=1, next state RUN.
  - Waits indefinitely; no timeout.
  - mem_pc_valid in RUN or LD_STALL is ignored.
- stall_count:
  - Increments in every cycle with pc_write=0, including RST_HOLD.
  - Saturates at all-ones (no wrap).
  - Cleared only by reset.
- Register 0 is not special: a match on address 0 still stalls.

Decomposition:
- Shared package holds:
  - PC_SRC_SEQ/BR/POP/RST encodings.
  - FSM state enum {RST_HOLD, RUN, LD_STALL, RET_WAIT}.
  - Control-signal bit positions (MemR, RegWrite, PopPc), reused by the buffers.
- One natural sub-module, hazard_compare: a pure combinational load-use match, reusable by a future forwarding unit.
- The FSM and counters stay in hazard_controller.

Test Plan:
- Reset low 3 cycles, release, RESET_CYCLES=2: pc_write=0 for 1 cycle, then pc_src=11 with pc_write=1, then RUN with busy=0; stall_count=1.
- Load-use: ex_mem_read=1, ex_write_add=3, dec_src2=3, dec_use2=1, dec_valid=1 → exactly one cycle pc_write=0, fd_write=0, de_flush=1, then normal; with LOAD_STALL_CYCLES=2, two cycles.
- Load-use plus ex_branch_taken in the same cycle → pc_src=01, pc_write=1, fd_flush=1, de_flush=1, no stall, stall_count unchanged.
- dec_ret=1, then mem_pc_valid after 3 cycles → 3 cycles pc_write=0 with fd_flush=1, then one cycle pc_src=10 with pc_write=1, busy back to 0.
- Reset asserted mid RET_WAIT → outputs go to reset values immediately (asynchronously); a later mem_pc_valid is ignored until RUN.
- CNT_W=4, force 20 stall cycles → stall_count saturates at 15.
